// File: rtl/vram_flip_ctrl_if.sv
// Bus bundle for vram_flip_ctrl: CPU-side requests, VIDEO_BUF and VRAM port A.
// The controller uses the slave modport; the MIO/memory side uses master.
interface vram_flip_ctrl_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned CNT_W = 16;

  logic              flip_req;
  logic              v_sync;
  logic              cpu_buf_we;
  logic [ADDR_W-1:0] cpu_buf_addr;
  logic [DATA_W-1:0] cpu_buf_din;
  logic              cpu_vram_we;
  logic [ADDR_W-1:0] cpu_vram_addr;
  logic [DATA_W-1:0] cpu_vram_din;
  logic [DATA_W-1:0] buf_dout;
  logic [ADDR_W-1:0] buf_addr;
  logic              buf_we;
  logic [DATA_W-1:0] buf_din;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_we;
  logic [DATA_W-1:0] vram_din;
  logic              cpu_ready;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  frame_cnt;
  logic              overrun;

  modport slave (
    input  flip_req, v_sync, cpu_buf_we, cpu_buf_addr, cpu_buf_din,
           cpu_vram_we, cpu_vram_addr, cpu_vram_din, buf_dout,
    output buf_addr, buf_we, buf_din, vram_addr, vram_we, vram_din,
           cpu_ready, busy, done, frame_cnt, overrun
  );

  modport master (
    output flip_req, v_sync, cpu_buf_we, cpu_buf_addr, cpu_buf_din,
           cpu_vram_we, cpu_vram_addr, cpu_vram_din, buf_dout,
    input  buf_addr, buf_we, buf_din, vram_addr, vram_we, vram_din,
           cpu_ready, busy, done, frame_cnt, overrun
  );
endinterface

// File: rtl/vram_flip_ctrl.sv
// Double-buffer flip: on request, waits for v_sync onset then copies DEPTH bytes
// VIDEO_BUF -> VRAM while stalling the CPU. Optional stats via VRAM_FLIP_STATS_EN.
module vram_flip_ctrl #(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 19200,
  parameter bit          VSYNC_ACT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  vram_flip_ctrl_if.slave   bus
);
  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned CNT_W = 16;
  localparam logic [PTR_W-1:0]  DEPTH_P = PTR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, COPY, DONE} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic               wr_valid_q, wr_valid_d;
  logic               pending_q, pending_d;
  logic               vs_q, vs_d;
  logic               vs_prev_q, vs_prev_d;
  logic               vs_edge;

  // Sync flops start at the active level so a held-active v_sync cannot fake an edge
  assign vs_edge = (vs_q == VSYNC_ACT) && (vs_prev_q != VSYNC_ACT);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.flip_req) state_d = WAIT_VS;
      WAIT_VS: if (vs_edge) state_d = COPY;
      COPY:    if (wr_valid_q && (wr_ptr_q == LAST_A)) state_d = DONE;
      DONE:    state_d = (pending_q || bus.flip_req) ? WAIT_VS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.buf_addr  = bus.cpu_buf_addr;
    bus.buf_we    = bus.cpu_buf_we;
    bus.buf_din   = bus.cpu_buf_din;
    bus.vram_addr = bus.cpu_vram_addr;
    bus.vram_we   = bus.cpu_vram_we;
    bus.vram_din  = bus.cpu_vram_din;
    bus.cpu_ready = 1'b1;
    bus.done      = 1'b0;
    bus.busy      = (state_q != IDLE) || pending_q;
    unique case (state_q)
      COPY: begin
        // Read address is held on the last byte once the pointer passes it
        bus.buf_addr  = (rd_ptr_q < DEPTH_P) ? rd_ptr_q[ADDR_W-1:0] : LAST_A;
        bus.buf_we    = 1'b0;
        bus.vram_addr = wr_ptr_q;
        bus.vram_we   = wr_valid_q;
        bus.vram_din  = bus.buf_dout;
        bus.cpu_ready = 1'b0;
      end
      DONE: begin
        bus.buf_we    = 1'b0;
        bus.vram_we   = 1'b0;
        bus.cpu_ready = 1'b0;
        bus.done      = 1'b1;
      end
      default: ;
    endcase
  end

  // Copy pointers, coalesced flip request and v_sync synchroniser
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    wr_valid_d = 1'b0;
    pending_d  = pending_q;
    vs_d       = bus.v_sync;
    vs_prev_d  = vs_q;
    unique case (state_q)
      WAIT_VS: rd_ptr_d = '0;
      COPY: begin
        pending_d = pending_q || bus.flip_req;
        if (rd_ptr_q < DEPTH_P) begin
          wr_ptr_d   = rd_ptr_q[ADDR_W-1:0];
          wr_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        end
      end
      DONE:    pending_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      wr_valid_q <= 1'b0;
      pending_q  <= 1'b0;
      vs_q       <= VSYNC_ACT;
      vs_prev_q  <= VSYNC_ACT;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_valid_q <= wr_valid_d;
      pending_q  <= pending_d;
      vs_q       <= vs_d;
      vs_prev_q  <= vs_prev_d;
    end
  end

`ifdef VRAM_FLIP_STATS_EN
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             overrun_q, overrun_d;

  // A vsync onset during COPY means the copy straddled a displayed frame
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    overrun_d   = overrun_q;
    if (state_q == DONE) frame_cnt_d = frame_cnt_q + CNT_W'(1);
    if ((state_q == COPY) && vs_edge) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
  assign bus.overrun   = overrun_q;
`else
  assign bus.frame_cnt = '0;
  assign bus.overrun   = 1'b0;
`endif

endmodule

// File: tb/tb_vram_flip_ctrl.sv
// Directed bench for vram_flip_ctrl with DEPTH=16; expectations follow VRAM_FLIP_STATS_EN.
module tb_vram_flip_ctrl;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
`ifdef VRAM_FLIP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  vram_flip_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_flip_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .VSYNC_ACT(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] buf_mem  [256];
  logic [DATA_W-1:0] vram_mem [256];
  int wa_q[$];
  int wd_q[$];
  int wc_q[$];
  int cyc;
  int done_cnt;
  int stall_cnt;
  int tests;
  int fails;

  // Memory models plus write/done/stall logging
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.buf_we === 1'b1) buf_mem[bus.buf_addr] <= bus.buf_din;
    bus.buf_dout <= buf_mem[bus.buf_addr];
    if (bus.vram_we === 1'b1) begin
      vram_mem[bus.vram_addr] <= bus.vram_din;
      wa_q.push_back(int'(bus.vram_addr));
      wd_q.push_back(int'(bus.vram_din));
      wc_q.push_back(cyc);
    end
    if (bus.done === 1'b1) done_cnt = done_cnt + 1;
    if (bus.cpu_ready === 1'b0) stall_cnt = stall_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flip_req      = 1'b0;
    bus.v_sync        = 1'b1;
    bus.cpu_buf_we    = 1'b0;
    bus.cpu_buf_addr  = '0;
    bus.cpu_buf_din   = '0;
    bus.cpu_vram_we   = 1'b0;
    bus.cpu_vram_addr = '0;
    bus.cpu_vram_din  = '0;
  endtask

  task automatic clear_logs();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    done_cnt  = 0;
    stall_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic preload(input logic [DATA_W-1:0] base);
    for (int i = 0; i < int'(DEPTH); i++) begin
      bus.cpu_buf_we   = 1'b1;
      bus.cpu_buf_addr = ADDR_W'(i);
      bus.cpu_buf_din  = base + DATA_W'(i);
      step();
    end
    bus.cpu_buf_we = 1'b0;
  endtask

  task automatic flip_pulse();
    bus.flip_req = 1'b1;
    step();
    bus.flip_req = 1'b0;
  endtask

  task automatic vs_pulse();
    bus.v_sync = 1'b0;
    step();
    step();
    step();
    bus.v_sync = 1'b1;
  endtask

  task automatic wait_copy(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      if (bus.cpu_ready === 1'b0) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      if (bus.busy === 1'b0) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    rst = 1'b1;
    #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests++; if (bus.cpu_ready !== 1'b1) begin fails++; $display("FAIL reset_cpu_ready: got %b want 1", bus.cpu_ready); end
    tests++; if (bus.vram_we !== 1'b0) begin fails++; $display("FAIL reset_vram_we: got %b want 0", bus.vram_we); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.done); end
    tests++; if (bus.frame_cnt !== 16'd0) begin fails++; $display("FAIL reset_frame_cnt: got %0d want 0", bus.frame_cnt); end
    tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    rst = 1'b0;
    bus.cpu_buf_we   = 1'b1;
    bus.cpu_buf_addr = 8'd5;
    bus.cpu_buf_din  = 8'hA5;
    #1;
    tests++; if ({bus.buf_we, bus.buf_addr, bus.buf_din} !== {1'b1, 8'd5, 8'hA5})
      begin fails++; $display("FAIL passthru_buf: got we=%b addr=%0d din=%h want we=1 addr=5 din=a5", bus.buf_we, bus.buf_addr, bus.buf_din); end
    step();
    bus.cpu_buf_we = 1'b0;
    tests++; if (buf_mem[5] !== 8'hA5) begin fails++; $display("FAIL passthru_buf_mem: got %h want a5", buf_mem[5]); end
  endtask

  task automatic test_basic_flip();
    bit ok;
    do_reset();
    preload(8'h10);
    vs_pulse();
    step();
    tests++; if ({bus.busy, bus.cpu_ready} !== 2'b01) begin fails++; $display("FAIL idle_vs_ignored: got busy=%b ready=%b want busy=0 ready=1", bus.busy, bus.cpu_ready); end
    clear_logs();
    flip_pulse();
    step();
    tests++; if ({bus.busy, bus.cpu_ready} !== 2'b11) begin fails++; $display("FAIL wait_vs_state: got busy=%b ready=%b want busy=1 ready=1", bus.busy, bus.cpu_ready); end
    flip_pulse();
    vs_pulse();
    wait_idle(60, ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_timeout: busy still %b want 0", bus.busy); end
    tests++; if (wa_q.size() != 16) begin fails++; $display("FAIL basic_write_count: got %0d want 16", wa_q.size()); end
    for (int i = 0; i < wa_q.size() && i < 16; i++) begin
      tests++;
      if (wa_q[i] != i || wd_q[i] != (i + 'h10) || wc_q[i] != wc_q[0] + i) begin
        fails++;
        $display("FAIL basic_write_%0d: got addr=%0d data=%h cyc_off=%0d want addr=%0d data=%h cyc_off=%0d",
                 i, wa_q[i], wd_q[i], wc_q[i] - wc_q[0], i, i + 'h10, i);
      end
    end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
    tests++; if (bus.frame_cnt !== (STATS ? 16'd1 : 16'd0)) begin fails++; $display("FAIL basic_frame_cnt: got %0d want %0d", bus.frame_cnt, STATS ? 1 : 0); end
    tests++; if (stall_cnt != 18) begin fails++; $display("FAIL basic_stall_clks: got %0d want 18", stall_cnt); end
  endtask

  task automatic test_stall();
    bit ok;
    bit granted;
    int ff_cnt;
    int a3_cnt;
    do_reset();
    clear_logs();
    flip_pulse();
    bus.v_sync = 1'b0;
    wait_copy(10, ok);
    tests++; if (!ok) begin fails++; $display("FAIL stall_copy_start: cpu_ready=%b want 0", bus.cpu_ready); end
    bus.cpu_vram_we   = 1'b1;
    bus.cpu_vram_addr = 8'd3;
    bus.cpu_vram_din  = 8'hFF;
    step();
    step();
    bus.v_sync = 1'b1;
    granted = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bus.cpu_ready === 1'b1) begin granted = 1'b1; break; end
      step();
    end
    tests++; if (!granted) begin fails++; $display("FAIL stall_grant: cpu_ready=%b want 1", bus.cpu_ready); end
    ff_cnt = 0;
    foreach (wd_q[i]) if (wd_q[i] == 'hFF) ff_cnt++;
    tests++; if (ff_cnt != 0) begin fails++; $display("FAIL stall_no_early_write: got %0d want 0", ff_cnt); end
    step();
    bus.cpu_vram_we = 1'b0;
    step();
    ff_cnt = 0;
    a3_cnt = 0;
    foreach (wa_q[i]) begin
      if (wa_q[i] == 3 && wd_q[i] == 'hFF) ff_cnt++;
      if (wa_q[i] == 3) a3_cnt++;
    end
    tests++; if (ff_cnt != 1) begin fails++; $display("FAIL stall_cpu_write_once: got %0d want 1", ff_cnt); end
    tests++; if (a3_cnt != 2) begin fails++; $display("FAIL stall_addr3_writes: got %0d want 2", a3_cnt); end
    tests++; if (wa_q.size() != 17) begin fails++; $display("FAIL stall_total_writes: got %0d want 17", wa_q.size()); end
    tests++; if (vram_mem[3] !== 8'hFF) begin fails++; $display("FAIL stall_vram3: got %h want ff", vram_mem[3]); end
  endtask

  task automatic test_queued();
    bit ok;
    do_reset();
    clear_logs();
    flip_pulse();
    bus.v_sync = 1'b0;
    wait_copy(10, ok);
    tests++; if (!ok) begin fails++; $display("FAIL queued_copy_start: cpu_ready=%b want 0", bus.cpu_ready); end
    bus.v_sync = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      flip_pulse();
    end
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done_cnt >= 1) begin ok = 1'b1; break; end
      step();
    end
    tests++; if (!ok) begin fails++; $display("FAIL queued_first_done: got %0d done want 1", done_cnt); end
    step();
    step();
    step();
    step();
    tests++; if ({bus.busy, bus.cpu_ready} !== 2'b11) begin fails++; $display("FAIL queued_wait_vs: got busy=%b ready=%b want busy=1 ready=1", bus.busy, bus.cpu_ready); end
    tests++; if (done_cnt != 1 || wa_q.size() != 16) begin fails++; $display("FAIL queued_no_early_copy: got done=%0d writes=%0d want done=1 writes=16", done_cnt, wa_q.size()); end
    vs_pulse();
    wait_idle(60, ok);
    tests++; if (!ok) begin fails++; $display("FAIL queued_timeout: busy=%b want 0", bus.busy); end
    tests++; if (done_cnt != 2) begin fails++; $display("FAIL queued_done_count: got %0d want 2", done_cnt); end
    tests++; if (wa_q.size() != 32) begin fails++; $display("FAIL queued_write_count: got %0d want 32", wa_q.size()); end
    tests++; if (bus.frame_cnt !== (STATS ? 16'd2 : 16'd0)) begin fails++; $display("FAIL queued_frame_cnt: got %0d want %0d", bus.frame_cnt, STATS ? 2 : 0); end
    vs_pulse();
    step();
    tests++; if (bus.busy !== 1'b0 || done_cnt != 2) begin fails++; $display("FAIL queued_stays_idle: got busy=%b done=%0d want busy=0 done=2", bus.busy, done_cnt); end
  endtask

  task automatic test_flip_at_done();
    bit ok;
    do_reset();
    clear_logs();
    flip_pulse();
    vs_pulse();
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bus.done === 1'b1) begin ok = 1'b1; break; end
      step();
    end
    tests++; if (!ok) begin fails++; $display("FAIL at_done_timeout: done=%b want 1", bus.done); end
    flip_pulse();
    tests++; if ({bus.busy, bus.cpu_ready} !== 2'b11) begin fails++; $display("FAIL at_done_requeue: got busy=%b ready=%b want busy=1 ready=1", bus.busy, bus.cpu_ready); end
    vs_pulse();
    wait_idle(60, ok);
    tests++; if (!ok || done_cnt != 2) begin fails++; $display("FAIL at_done_second_copy: got idle=%b done=%0d want idle=1 done=2", ok, done_cnt); end
  endtask

  task automatic test_midcopy_reset();
    bit ok;
    do_reset();
    preload(8'h40);
    clear_logs();
    flip_pulse();
    bus.v_sync = 1'b0;
    wait_copy(10, ok);
    tests++; if (!ok) begin fails++; $display("FAIL midrst_copy_start: cpu_ready=%b want 0", bus.cpu_ready); end
    bus.v_sync = 1'b1;
    repeat (7) step();
    rst = 1'b1;
    step();
    tests++; if ({bus.busy, bus.cpu_ready, bus.vram_we, bus.done} !== 4'b0100)
      begin fails++; $display("FAIL midrst_idle: got busy=%b ready=%b vram_we=%b done=%b want 0 1 0 0", bus.busy, bus.cpu_ready, bus.vram_we, bus.done); end
    rst = 1'b0;
    repeat (20) step();
    tests++; if (done_cnt != 0 || bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_no_done: got done=%0d busy=%b want done=0 busy=0", done_cnt, bus.busy); end
    tests++; if (wa_q.size() != 7) begin fails++; $display("FAIL midrst_write_count: got %0d want 7", wa_q.size()); end
    tests++; if ({vram_mem[0], vram_mem[6], vram_mem[7]} !== {8'h40, 8'h46, 8'h17})
      begin fails++; $display("FAIL midrst_partial: got %h %h %h want 40 46 17", vram_mem[0], vram_mem[6], vram_mem[7]); end
  endtask

  task automatic test_overrun();
    bit ok;
    do_reset();
    clear_logs();
    tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL ovr_initial: got %b want 0", bus.overrun); end
    flip_pulse();
    bus.v_sync = 1'b0;
    wait_copy(10, ok);
    bus.v_sync = 1'b1;
    step();
    step();
    vs_pulse();
    wait_idle(60, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ovr_timeout: busy=%b want 0", bus.busy); end
    tests++; if (bus.overrun !== STATS) begin fails++; $display("FAIL ovr_set: got %b want %b", bus.overrun, STATS); end
    flip_pulse();
    vs_pulse();
    wait_idle(60, ok);
    tests++; if (!ok || done_cnt != 2) begin fails++; $display("FAIL ovr_second_flip: got idle=%b done=%0d want idle=1 done=2", ok, done_cnt); end
    tests++; if (bus.overrun !== STATS) begin fails++; $display("FAIL ovr_sticky: got %b want %b", bus.overrun, STATS); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL ovr_cleared: got %b want 0", bus.overrun); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    clear_logs();
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_flip();
    test_stall();
    test_queued();
    test_flip_at_done();
    test_midcopy_reset();
    test_overrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vram_flip_ctrl.md
Name: vram_flip_ctrl

Overview:
Double-buffer flip controller between MIO_BUS, VIDEO_BUF (back buffer) and VRAM_B port A (front buffer).
- The CPU draws into VIDEO_BUF.
- On a flip request, the block waits for the start of vertical sync, then streams DEPTH bytes from VIDEO_BUF into VRAM at one byte per clock.
- While the copy runs, both memory ports belong to the block and CPU accesses are stalled. Otherwise the CPU signals pass straight through.
- Clocked by clk_IO.

Parameters:
ADDR_W, 15, buffer/VRAM address width
DATA_W, 8, pixel width
DEPTH, 19200, bytes copied per flip (160x120x8bpp); must be 2..2^ADDR_W
VSYNC_ACT, 0, active level of v_sync

Ports:
clk  in  1  system clock (clk_IO domain)
rst  in  1  synchronous, active-high reset
flip_req  in  1  single-cycle flip request from MIO_BUS
v_sync  in  1  VGA vertical sync from vga_controller
cpu_buf_we  in  1  CPU write strobe to VIDEO_BUF
cpu_buf_addr  in  ADDR_W  CPU VIDEO_BUF address
cpu_buf_din  in  DATA_W  CPU VIDEO_BUF write data
cpu_vram_we  in  1  CPU direct VRAM write strobe
cpu_vram_addr  in  ADDR_W  CPU VRAM address
cpu_vram_din  in  DATA_W  CPU VRAM write data
buf_dout  in  DATA_W  VIDEO_BUF read data, valid 1 clk after address
buf_addr  out  ADDR_W  VIDEO_BUF address
buf_we  out  1  VIDEO_BUF write enable
buf_din  out  DATA_W  VIDEO_BUF write data
vram_addr  out  ADDR_W  VRAM port A address
vram_we  out  1  VRAM port A write enable
vram_din  out  DATA_W  VRAM port A write data
cpu_ready  out  1  0 = CPU memory access stalled (ANDed into MIO_ready)
busy  out  1  flip pending or copy in progress
done  out  1  one-cycle pulse when a copy completes
frame_cnt  out  16  completed flips (optional feature)
overrun  out  1  sticky tearing flag (optional feature)

Behaviour:
- Input sync: v_sync is registered once. vs_edge = registered value transitions from inactive to VSYNC_ACT.
- Reset (state) on rst: state=IDLE, rd_ptr=0, wr_valid=0, pending=0.
- Reset (outputs) on rst: busy=0, done=0, cpu_ready=1, frame_cnt=0, overrun=0, all write enables 0.
- States: IDLE, WAIT_VS, COPY, DONE.
- IDLE:
  - CPU ports pass through combinationally: buf_addr/we/din = cpu_buf_*, vram_addr/we/din = cpu_vram_*.
  - flip_req -> WAIT_VS.
- WAIT_VS:
  - Pass-through continues. busy=1, cpu_ready=1.
  - On vs_edge -> COPY with rd_ptr=0, wr_valid=0.
- COPY (busy=1, cpu_ready=0; CPU strobes ignored, buf_we=0):
  - Each clk, buf_addr=rd_ptr.
  - wr_ptr<=rd_ptr and wr_valid<=1 while rd_ptr<DEPTH; rd_ptr increments.
  - vram_we=wr_valid, vram_addr=wr_ptr, vram_din=buf_dout.
  - After the write at wr_ptr=DEPTH-1 -> DONE.
  - Total COPY length is DEPTH+1 clocks; no address wraps or repeats.
- DONE: done=1 for one clk, frame_cnt+1, cpu_ready=0, then
  - -> WAIT_VS if pending=1 (pending cleared),
  - else -> IDLE.
- Flip requests outside IDLE:
  - flip_req during WAIT_VS is absorbed.
  - flip_req during COPY/DONE sets pending. Multiple such requests coalesce into one pending flip.
  - flip_req in the same clk as the DONE->IDLE transition also sets pending, so the next state is WAIT_VS.
- vs_edge in IDLE or DONE is ignored.
- rst mid-copy aborts immediately; VRAM keeps the partially copied content.
- busy = (state != IDLE) | pending.

Optional Feature:
Macro: VRAM_FLIP_STATS_EN.
- Defined:
  - frame_cnt counts completed copies and wraps at 16 bits.
  - overrun is set when vs_edge occurs while state==COPY (the copy spans a visible frame). It is cleared only by rst.
- Undefined: frame_cnt is constant 0 and overrun is constant 0; no counter logic is synthesized.

Test Plan:
1. All scenarios use DEPTH=16. Reset state: rst=1 for 2 clks -> busy=0, cpu_ready=1, vram_we=0, frame_cnt=0; then CPU write buf addr 5 data 0xA5 -> buf_we=1, buf_addr=5, buf_din=0xA5 in the same clk.
2. Basic flip: preload buffer[i]=i+0x10, flip_req, then v_sync falling edge -> COPY starts; vram_we asserted 16 consecutive clks with addr 0..15 and data 0x10..0x1F; done pulses once; frame_cnt=1; cpu_ready=0 for exactly 18 clks (COPY 17 + DONE 1).
3. Stall during COPY: cpu_vram_we=1 addr 3 data 0xFF held during COPY -> no VRAM write to addr 3 until back in IDLE, then written once.
4. Queued flips: 3 flip_req pulses during COPY -> exactly one extra copy after the next vs_edge; frame_cnt=2; busy then drops.
5. Mid-copy reset: rst asserted at the 8th COPY clk -> next clk state IDLE, vram_we=0, busy=0, no done pulse.
6. Overrun (stats on): v_sync period shorter than 17 clks during COPY -> overrun=1 and stays 1 through further flips until rst.
